// File: rtl/prbs31_bert_ctrl.sv
// prbs31_bert_ctrl
//   Bit-error-rate test sequencer for PRBS31 (x^31 + x^28 + 1). Transmits the
//   pattern and self-synchronises a checker onto the received stream. It then
//   walks SEED -> HUNT -> LOCKED -> DONE and counts compared bits and errors
//   over a programmed test length.
//
// Ports
//   clk        single clock, posedge
//   rst_n      asynchronous reset, active HIGH despite the name
//   start      begin a new test when idle or done (level-sampled)
//   abort      return to IDLE from any state; beats start
//   test_len   LOCKED bits to compare, 0 = run until abort; latched on start
//   inj_err    invert the transmitted bit of this cycle
//   rx_bit     received bit, qualified by rx_valid
//   rx_valid   checker advances only when set
//   tx_bit     PRBS31 output (lfsr[30] ^ inj_err)
//   tx_valid   state != IDLE
//   busy       state is SEED, HUNT or LOCKED
//   locked     state is LOCKED
//   done       state is DONE (level)
//   lost_lock  one-cycle pulse on LOCKED -> HUNT
//   bit_cnt    bits compared while LOCKED (saturating)
//   err_cnt    errors counted while LOCKED (saturating)
//   err_sat    sticky flag: err_cnt reached all-ones
module prbs31_bert_ctrl #(
  parameter int LEN_W  = 24,
  parameter int CNT_W  = 16,
  parameter int LOCK_N = 64,
  parameter int LOSS_N = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] test_len,
  input  logic             inj_err,
  input  logic             rx_bit,
  input  logic             rx_valid,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic             lost_lock,
  output logic [LEN_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sat
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEED   = 3'd1,
    S_HUNT   = 3'd2,
    S_LOCKED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [30:0]      lfsr_q;
  logic [30:0]      hist_q;
  logic [4:0]       seed_cnt_q, seed_cnt_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [5:0]       win_bits_q, win_bits_d;
  logic [6:0]       win_errs_q, win_errs_d;
  logic [LEN_W-1:0] test_len_q, test_len_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sat_q, err_sat_d;
  logic             lost_q, lost_d;
  logic             tx_valid_q, busy_q, locked_q, done_q;

  logic             pred;
  logic             rx_err;
  logic             start_ok;
  logic [LEN_W-1:0] bit_cnt_inc;
  logic [CNT_W-1:0] err_cnt_inc;
  logic [6:0]       win_errs_inc;
  logic [7:0]       match_inc;

  // Self-synchronising checker: the next bit is predicted from the received
  // history itself, so one flipped bit shows up as three errors.
  assign pred         = hist_q[27] ^ hist_q[30];
  assign rx_err       = rx_bit ^ pred;
  assign start_ok     = start && !abort && (state_q == S_IDLE || state_q == S_DONE);
  assign bit_cnt_inc  = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + LEN_W'(1);
  assign err_cnt_inc  = (rx_err && !(&err_cnt_q)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  assign win_errs_inc = win_errs_q + {6'd0, rx_err};
  assign match_inc    = match_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    win_bits_d  = win_bits_q;
    win_errs_d  = win_errs_q;
    test_len_d  = test_len_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_sat_d   = err_sat_q;
    lost_d      = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d     = S_SEED;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
            win_bits_d  = '0;
            win_errs_d  = '0;
            bit_cnt_d   = '0;
            err_cnt_d   = '0;
            err_sat_d   = 1'b0;
            test_len_d  = test_len;
          end
        end
        S_SEED: begin
          // 31 bits fill the history; comparisons are meaningless before that.
          if (rx_valid) begin
            seed_cnt_d = seed_cnt_q + 5'd1;
            if (seed_cnt_q == 5'd30) begin
              state_d = S_HUNT;
            end
          end
        end
        S_HUNT: begin
          if (rx_valid) begin
            if (rx_err) begin
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_inc;
              if (match_inc == 8'(LOCK_N)) begin
                state_d    = S_LOCKED;
                // Loss window is aligned to the lock point.
                win_bits_d = '0;
                win_errs_d = '0;
              end
            end
          end
        end
        S_LOCKED: begin
          if (rx_valid) begin
            bit_cnt_d  = bit_cnt_inc;
            err_cnt_d  = err_cnt_inc;
            if (&err_cnt_inc) begin
              err_sat_d = 1'b1;
            end
            win_bits_d = win_bits_q + 6'd1;
            // The wrapping bit still counts toward the loss check of its window.
            win_errs_d = (win_bits_q == 6'd63) ? 7'd0 : win_errs_inc;
            if (test_len_q != '0 && bit_cnt_inc == test_len_q) begin
              state_d = S_DONE;
            end else if (win_errs_inc == 7'(LOSS_N)) begin
              state_d     = S_HUNT;
              match_cnt_d = '0;
              lost_d      = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= 31'd1;
      hist_q      <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      test_len_q  <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_sat_q   <= 1'b0;
      lost_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      win_bits_q  <= win_bits_d;
      win_errs_q  <= win_errs_d;
      test_len_q  <= test_len_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_sat_q   <= err_sat_d;
      lost_q      <= lost_d;
      tx_valid_q  <= (state_d != S_IDLE);
      busy_q      <= (state_d == S_SEED) || (state_d == S_HUNT) || (state_d == S_LOCKED);
      locked_q    <= (state_d == S_LOCKED);
      done_q      <= (state_d == S_DONE);

      if (start_ok) begin
        lfsr_q <= 31'd1;
      end else if (state_q != S_IDLE) begin
        lfsr_q <= {lfsr_q[29:0], lfsr_q[27] ^ lfsr_q[30]};
      end

      if (rx_valid) begin
        hist_q <= {hist_q[29:0], rx_bit};
      end
    end
  end

  assign tx_bit    = lfsr_q[30] ^ inj_err;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign locked    = locked_q;
  assign done      = done_q;
  assign lost_lock = lost_q;
  assign bit_cnt   = bit_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign err_sat   = err_sat_q;

endmodule

// File: tb/tb_prbs31_bert_ctrl.sv
// Bench for prbs31_bert_ctrl. Two instances run side by side from shared
// stimulus: u0 with default parameters, u1 with CNT_W=4 / LOSS_N=64. Each
// instance has its own loopback (rx = tx, optionally inverted) and its own
// behavioural model; every negedge both are compared against their models.
module tb_prbs31_bert_ctrl;

  localparam int M_IDLE = 0, M_SEED = 1, M_HUNT = 2, M_LOCKED = 3, M_DONE = 4;
  localparam int SLEN = 4096;

  typedef struct packed {
    int         st;
    int         seedc;
    int         matchc;
    int         bitc;
    int         errc;
    int         winb;
    int         wine;
    int         tl;
    int         tx_idx;
    int         m;
    bit         lost;
    bit         sat;
    bit [63:0]  rxmem;
  } mstate_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] test_len = '0;
  logic        inj_err = 1'b0;
  logic        rx_valid = 1'b1;
  logic        rx_inv = 1'b0;

  bit          sval [SLEN];
  int          total = 0;
  int          bad = 0;

  wire [47:0]  dut_vec [2];
  wire [47:0]  exp_vec [2];

  always #5 clk = ~clk;

  // Received bit m-k from the model's history ring; bits before reset read 0.
  function automatic bit hbit(input mstate_t s, input int k);
    if (k < 0) return 1'b0;
    return s.rxmem[k % 64];
  endfunction

  function automatic mstate_t step(input mstate_t s, input bit stt, input bit ab,
                                   input bit v, input bit rx, input int tl_in,
                                   input int loss_n, input int cmax);
    mstate_t n;
    bit e, accept, lossnow;
    n = s;
    n.lost = 1'b0;
    e = rx ^ hbit(s, s.m - 28) ^ hbit(s, s.m - 31);
    accept = !ab && stt && (s.st == M_IDLE || s.st == M_DONE);
    if (accept) n.tx_idx = 0;
    else if (s.st != M_IDLE) n.tx_idx = s.tx_idx + 1;
    if (ab) begin
      n.st = M_IDLE;
    end else if (accept) begin
      n.st = M_SEED; n.seedc = 0; n.matchc = 0; n.bitc = 0; n.errc = 0;
      n.sat = 1'b0; n.winb = 0; n.wine = 0; n.tl = tl_in;
    end else if (v) begin
      case (s.st)
        M_SEED: begin
          n.seedc = s.seedc + 1;
          if (n.seedc == 31) n.st = M_HUNT;
        end
        M_HUNT: begin
          n.matchc = e ? 0 : s.matchc + 1;
          if (n.matchc == 64) begin n.st = M_LOCKED; n.winb = 0; n.wine = 0; end
        end
        M_LOCKED: begin
          if (s.bitc < 24'hFF_FFFF) n.bitc = s.bitc + 1;
          if (e && s.errc < cmax) n.errc = s.errc + 1;
          if (n.errc == cmax) n.sat = 1'b1;
          n.winb = s.winb + 1;
          n.wine = s.wine + int'(e);
          lossnow = (n.wine == loss_n);
          if (n.winb == 64) begin n.winb = 0; n.wine = 0; end
          if (n.tl != 0 && n.bitc == n.tl) n.st = M_DONE;
          else if (lossnow) begin n.st = M_HUNT; n.matchc = 0; n.lost = 1'b1; end
        end
        default: ;
      endcase
    end
    if (v) begin
      n.rxmem[s.m % 64] = rx;
      n.m = s.m + 1;
    end
    return n;
  endfunction

  function automatic logic [47:0] expv(input mstate_t s, input bit inj, input bit sb);
    return {sb ^ inj, s.st != M_IDLE, (s.st >= M_SEED && s.st <= M_LOCKED),
            s.st == M_LOCKED, s.st == M_DONE, s.lost, s.sat,
            24'(s.bitc), 16'(s.errc)};
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int CW = (gi == 0) ? 16 : 4;
    localparam int LN = (gi == 0) ? 8 : 64;
    logic          tx, txv, bsy, lck, dn, lost, sat, rxb, sb;
    logic [23:0]   bc;
    logic [CW-1:0] ec;
    mstate_t       ms;

    assign rxb = rx_inv ? ~tx : tx;

    prbs31_bert_ctrl #(.LEN_W(24), .CNT_W(CW), .LOCK_N(64), .LOSS_N(LN)) u_dut (
      .clk(clk), .rst_n(rst), .start(start), .abort(abort), .test_len(test_len),
      .inj_err(inj_err), .rx_bit(rxb), .rx_valid(rx_valid),
      .tx_bit(tx), .tx_valid(txv), .busy(bsy), .locked(lck), .done(dn),
      .lost_lock(lost), .bit_cnt(bc), .err_cnt(ec), .err_sat(sat)
    );

    always @(posedge clk or posedge rst) begin
      if (rst) ms <= '0;
      else     ms <= step(ms, start, abort, rx_valid, rxb, int'(test_len), LN, (1 << CW) - 1);
    end

    assign sb = (ms.tx_idx < SLEN) ? sval[ms.tx_idx] : 1'b0;
    assign dut_vec[gi] = {tx, txv, bsy, lck, dn, lost, sat, bc, 16'(ec)};
    assign exp_vec[gi] = expv(ms, inj_err, sb);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        chk($sformatf("cycle_u%0d", i), 64'(dut_vec[i]), 64'(exp_vec[i]));
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Start a loopback test and wait for u0 to lock; checks the lock latency and
  // the first 31 transmitted bits of the reseeded LFSR.
  task automatic start_and_lock(input int len, input string tag);
    int n;
    logic [30:0] txw;
    test_len = 24'(len); start = 1'b1; cyc(1); start = 1'b0;
    n = 0; txw = '0;
    while (!g_inst[0].lck && n < 400) begin
      if (n < 31) txw[n] = g_inst[0].tx;
      cyc(1); n++;
    end
    chk({tag, "_lock_bits"}, 64'(n), 64'd95);
    chk({tag, "_seed_tx"}, 64'(txw), 64'h4000_0000);
    $display("%s: started len=%0d, locked after %0d bits", tag, len, n);
  endtask

  initial begin
    int n;
    for (int i = 0; i < SLEN; i++)
      sval[i] = (i < 31) ? (i == 30) : (sval[i-28] ^ sval[i-31]);
    fork monitor(); join_none

    cyc(2);
    chk("reset_u0", 64'(dut_vec[0]), 64'd0);
    chk("reset_u1", 64'(dut_vec[1]), 64'd0);
    rst = 1'b0;
    cyc(2);

    // 1: clean loopback, 1000 bits
    start_and_lock(1000, "t1");
    n = 0;
    while (!g_inst[0].dn && n < 1100) begin cyc(1); n++; end
    chk("t1_done_bits", 64'(n), 64'd1000);
    chk("t1_bit_cnt", 64'(g_inst[0].bc), 64'd1000);
    chk("t1_err_cnt", 64'(g_inst[0].ec), 64'd0);
    $display("t1: done bit_cnt=%0d err_cnt=%0d", g_inst[0].bc, g_inst[0].ec);

    // 2: one injected error while locked -> three counted errors
    start_and_lock(1000, "t2");
    cyc(10); inj_err = 1'b1; cyc(1); inj_err = 1'b0; cyc(40);
    chk("t2_still_locked", 64'(g_inst[0].lck), 64'd1);
    n = 0;
    while (!g_inst[0].dn && n < 1100) begin cyc(1); n++; end
    chk("t2_done", 64'(g_inst[0].dn), 64'd1);
    chk("t2_err_cnt_u0", 64'(g_inst[0].ec), 64'd3);
    chk("t2_err_cnt_u1", 64'(g_inst[1].ec), 64'd3);
    $display("t2: done err_cnt=%0d", g_inst[0].ec);

    // 3: inverted receive after lock -> loss after 8 errors, no relock
    start_and_lock(0, "t3");
    rx_inv = 1'b1;
    n = 0;
    while (!g_inst[0].lost && n < 50) begin cyc(1); n++; end
    chk("t3_lost_bits", 64'(n), 64'd8);
    chk("t3_err_cnt", 64'(g_inst[0].ec), 64'd8);
    chk("t3_unlocked", 64'(g_inst[0].lck), 64'd0);
    cyc(200);
    chk("t3_no_relock", 64'(g_inst[0].lck), 64'd0);
    chk("t3_err_hold", 64'(g_inst[0].ec), 64'd8);
    chk("t3_u1_err_sat_cnt", 64'(g_inst[1].ec), 64'd15);
    $display("t3: lost after %0d bits err_cnt=%0d", n, g_inst[0].ec);
    abort = 1'b1; cyc(1); abort = 1'b0; rx_inv = 1'b0; cyc(2);

    // 4: u1 (4-bit counter) saturates under periodic injection
    start_and_lock(500, "t4");
    for (int k = 0; k < 20; k++) begin
      inj_err = 1'b1; cyc(1); inj_err = 1'b0; cyc(7);
    end
    chk("t4_u1_err_cnt", 64'(g_inst[1].ec), 64'd15);
    chk("t4_u1_err_sat", 64'(g_inst[1].sat), 64'd1);
    chk("t4_u1_locked", 64'(g_inst[1].lck), 64'd1);
    n = 0;
    while (!g_inst[1].dn && n < 600) begin cyc(1); n++; end
    chk("t4_u1_bit_cnt", 64'(g_inst[1].bc), 64'd500);
    $display("t4: u1 err_cnt=%0d err_sat=%0d", g_inst[1].ec, g_inst[1].sat);
    abort = 1'b1; cyc(2); abort = 1'b0;

    // 5: rx_valid toggling, abort while locked
    test_len = 24'd0; start = 1'b1; cyc(1); start = 1'b0;
    n = 0;
    while (!g_inst[0].lck && n < 600) begin rx_valid = ~rx_valid; cyc(1); n++; end
    chk("t5_locked", 64'(g_inst[0].lck), 64'd1);
    n = 0;
    while (g_inst[0].bc != 24'd10 && n < 100) begin rx_valid = ~rx_valid; cyc(1); n++; end
    chk("t5_bit_cnt_pre", 64'(g_inst[0].bc), 64'd10);
    abort = 1'b1; rx_valid = 1'b1; cyc(1);
    chk("t5_idle_locked", 64'(g_inst[0].lck), 64'd0);
    chk("t5_idle_txv", 64'(g_inst[0].txv), 64'd0);
    chk("t5_idle_busy", 64'(g_inst[0].bsy), 64'd0);
    chk("t5_bit_cnt_frozen", 64'(g_inst[0].bc), 64'd10);
    start = 1'b1; cyc(5);
    chk("t5_abort_beats_start", 64'(g_inst[0].txv), 64'd0);
    chk("t5_bit_cnt_hold", 64'(g_inst[0].bc), 64'd10);
    $display("t5: aborted at bit_cnt=%0d", g_inst[0].bc);
    abort = 1'b0; start = 1'b0; cyc(1);

    // 6: asynchronous reset mid-LOCKED, then relock from the seed
    start_and_lock(0, "t6a");
    cyc(5); #3; rst = 1'b1; #1;
    chk("t6_async_u0", 64'(dut_vec[0]), 64'd0);
    chk("t6_async_u1", 64'(dut_vec[1]), 64'd0);
    @(negedge clk); rst = 1'b0; cyc(1);
    start_and_lock(0, "t6b");
    $display("t6: relocked after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
